// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dlyfilt.sv
`default_nettype none
// ============================================================================
//  Module   : gf180mcu_fd_sc_mcu9t5v0__dlyfilt
//  Brief    : Clocked deglitch stage for a dlyb chain output. Synchronizes I,
//             qualifies level changes over THR cycles, emits edge strobes.
//  Revision : 1.0  initial release
// ============================================================================
module gf180mcu_fd_sc_mcu9t5v0__dlyfilt #(
  parameter int CNT_W = 4
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic             CLK,
  input  logic             RST,
  input  logic             I,
  input  logic [CNT_W-1:0] THR,
  output logic             Z,
  output logic             ZR,
  output logic             ZF,
  output logic             BUSY
);

  typedef enum logic [0:0] {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_one_n  = CNT_W'(1);
  localparam logic [CNT_W:0]   c_one_n1 = (CNT_W + 1)'(1);

  logic             r_s1;
  logic             r_s2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_z;
  logic             r_zr;
  logic             r_zf;

  logic [CNT_W-1:0] w_thr_eff;
  logic [CNT_W:0]   w_cnt_inc;
  logic             w_thr_met;
  logic             w_mismatch;

  // A threshold of zero behaves as one; the extra bit keeps cnt+1 from wrapping.
  assign w_thr_eff  = (THR == '0) ? c_one_n : THR;
  assign w_cnt_inc  = {1'b0, r_cnt} + c_one_n1;
  assign w_thr_met  = (w_cnt_inc >= {1'b0, w_thr_eff});
  assign w_mismatch = (r_s2 != r_z);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= ST_STABLE;
      r_cnt   <= '0;
      r_z     <= 1'b0;
      r_zr    <= 1'b0;
      r_zf    <= 1'b0;
    end else begin
      r_s1 <= I;
      r_s2 <= r_s1;
      r_zr <= 1'b0;
      r_zf <= 1'b0;
      case (r_state)
        ST_STABLE: begin
          // cnt is 0 here, so "met" reduces to an effective threshold of 1.
          if (w_mismatch && w_thr_met) begin
            r_z   <= r_s2;
            r_zr  <= r_s2;
            r_zf  <= ~r_s2;
            r_cnt <= '0;
          end else if (w_mismatch) begin
            r_state <= ST_QUALIFY;
            r_cnt   <= c_one_n;
          end else begin
            r_cnt <= '0;
          end
        end
        ST_QUALIFY: begin
          if (!w_mismatch) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
          end else if (w_thr_met) begin
            r_z     <= r_s2;
            r_zr    <= r_s2;
            r_zf    <= ~r_s2;
            r_state <= ST_STABLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc[CNT_W-1:0];
          end
        end
        default: begin
          r_state <= ST_STABLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign Z    = r_z;
  assign ZR   = r_zr;
  assign ZF   = r_zf;
  assign BUSY = (r_state == ST_QUALIFY);

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dlyfilt.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gf180mcu_fd_sc_mcu9t5v0__dlyfilt
//  Brief    : Directed and random checks of the deglitch filter against a
//             run-length reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gf180mcu_fd_sc_mcu9t5v0__dlyfilt;

  localparam int W = 4;

  logic         CLK;
  logic         RST;
  logic         I;
  logic [W-1:0] THR;
  logic         Z;
  logic         ZR;
  logic         ZF;
  logic         BUSY;

  int checks = 0;
  int errors = 0;

  // Reference: I delayed two cycles, plus the length of the current mismatch run.
  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;
  logic m_z  = 1'b0;
  logic m_zr = 1'b0;
  logic m_zf = 1'b0;
  int   m_run = 0;

  gf180mcu_fd_sc_mcu9t5v0__dlyfilt #(.CNT_W(W)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .I    (I),
    .THR  (THR),
    .Z    (Z),
    .ZR   (ZR),
    .ZF   (ZF),
    .BUSY (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int t;
    if (RST) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_z = 1'b0; m_zr = 1'b0; m_zf = 1'b0; m_run = 0;
    end else begin
      t = (THR == 0) ? 1 : int'(THR);
      m_zr = 1'b0;
      m_zf = 1'b0;
      if (m_s2 != m_z) begin
        m_run++;
        if (m_run >= t) begin
          m_z   = m_s2;
          m_zr  = m_s2;
          m_zf  = ~m_s2;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = I;
    end
  endtask

  task automatic step(input logic i_v, input logic [W-1:0] thr_v, input logic rst_v);
    @(negedge CLK);
    I = i_v; THR = thr_v; RST = rst_v;
    model_edge();
    @(posedge CLK);
    #1;
    chk("z",    32'(Z),    32'(m_z));
    chk("zr",   32'(ZR),   32'(m_zr));
    chk("zf",   32'(ZF),   32'(m_zf));
    chk("busy", 32'(BUSY), 32'(m_run > 0));
    chk("cnt",  32'(dut.r_cnt), 32'(m_run));
    chk("excl", 32'(ZR & ZF), 32'(0));
  endtask

  initial begin
    logic cur;
    int   thr_r;
    RST = 1'b1; I = 1'b0; THR = 4'd4;

    // Reset state
    step(1'b0, 4'd4, 1'b1);
    step(1'b0, 4'd4, 1'b1);
    chk("rst_z", 32'(Z), 32'(0));
    chk("rst_busy", 32'(BUSY), 32'(0));

    // THR=4: 0->1 held, Z rises exactly at e+5
    for (int k = 0; k < 5; k++) step(1'b1, 4'd4, 1'b0);
    chk("thr4_z_before", 32'(Z), 32'(0));
    step(1'b1, 4'd4, 1'b0);
    chk("thr4_z_rise", 32'(Z), 32'(1));
    chk("thr4_zr", 32'(ZR), 32'(1));
    step(1'b1, 4'd4, 1'b0);
    chk("thr4_zr_once", 32'(ZR), 32'(0));

    // Short pulse shorter than threshold: no change
    step(1'b0, 4'd4, 1'b1);
    step(1'b1, 4'd4, 1'b0);
    step(1'b1, 4'd4, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b0, 4'd4, 1'b0);
    chk("glitch_z", 32'(Z), 32'(0));
    chk("glitch_cnt", 32'(dut.r_cnt), 32'(0));

    // THR=0 and THR=1: 2-cycle follow, toggling every 4 cycles
    cur = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (k % 4 == 0) cur = ~cur;
      step(cur, (k < 12) ? 4'd0 : 4'd1, 1'b0);
    end

    // THR=15: counter reaches 14 without wrapping, Z rises at e+16
    step(1'b0, 4'd15, 1'b1);
    for (int k = 0; k < 16; k++) step(1'b1, 4'd15, 1'b0);
    chk("thr15_cnt14", 32'(dut.r_cnt), 32'(14));
    chk("thr15_z_before", 32'(Z), 32'(0));
    step(1'b1, 4'd15, 1'b0);
    chk("thr15_z_rise", 32'(Z), 32'(1));

    // THR lowered mid-qualification takes effect on the next edge
    step(1'b0, 4'd8, 1'b1);
    for (int k = 0; k < 7; k++) step(1'b1, 4'd8, 1'b0);
    chk("thr_chg_cnt5", 32'(dut.r_cnt), 32'(5));
    step(1'b1, 4'd3, 1'b0);
    chk("thr_chg_z", 32'(Z), 32'(1));

    // Reset on the qualifying edge wins
    step(1'b0, 4'd2, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b1, 4'd2, 1'b0);
    step(1'b1, 4'd2, 1'b1);
    chk("rst_win_z", 32'(Z), 32'(0));
    chk("rst_win_zr", 32'(ZR), 32'(0));
    chk("rst_win_busy", 32'(BUSY), 32'(0));
    step(1'b1, 4'd2, 1'b0);
    chk("rst_next_zr", 32'(ZR), 32'(0));

    // Random traffic
    cur   = 1'b0;
    thr_r = 3;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) cur = ~cur;
      if ($urandom_range(0, 40) == 0) thr_r = $urandom_range(0, 6);
      step(cur, W'(thr_r), ($urandom_range(0, 250) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
